// File: rtl/sample_fifo.sv
// Synchronous sample buffer between the function generator and its consumers.
// Optional sticky overflow/underflow flags are built when SAMPLE_FIFO_ERR_FLAGS_EN is defined.
module sample_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clrh_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_accept;
    logic                  rd_accept;

    assign full_o        = (count == DEPTH_CNT);
    assign empty_o       = (count == '0);
    assign almost_full_o = (count >= AFULL_CNT);
    assign count_o       = count;

    // Full and empty are judged on the registered count, so a write into a
    // full buffer is dropped even when a read frees a slot in the same cycle.
    assign wr_accept = wr_en_i && !full_o  && !clrh_i;
    assign rd_accept = rd_en_i && !empty_o && !clrh_i;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            rd_valid_o <= 1'b0;
            data_o     <= '0;
        end else if (clrh_i) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_accept;
            if (wr_accept) begin
                wptr <= wptr + ONE_PTR;
            end
            if (rd_accept) begin
                rptr   <= rptr + ONE_PTR;
                data_o <= mem[rptr];
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (clrh_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_en_i && full_o) begin
                overflow_o <= 1'b1;
            end
            if (rd_en_i && empty_o) begin
                underflow_o <= 1'b1;
            end
        end
    end
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo; works with or without SAMPLE_FIFO_ERR_FLAGS_EN.
module tb_sample_fifo;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    localparam logic FLAGS = 1'b1;
`else
    localparam logic FLAGS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clrh_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          rd_en_i = 1'b0;
    logic [DW-1:0] data_o;
    logic          rd_valid_o;
    logic          full_o;
    logic          empty_o;
    logic          almost_full_o;
    logic [AW:0]   count_o;
    logic          overflow_o;
    logic          underflow_o;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] last_pop;

    sample_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(12)) dut (
        .clk(clk), .rst(rst), .clrh_i(clrh_i), .wr_en_i(wr_en_i), .data_i(data_i),
        .rd_en_i(rd_en_i), .data_o(data_o), .rd_valid_o(rd_valid_o), .full_o(full_o),
        .empty_o(empty_o), .almost_full_o(almost_full_o), .count_o(count_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({empty_o, full_o, almost_full_o, rd_valid_o, overflow_o, underflow_o} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got e=%b f=%b af=%b v=%b of=%b uf=%b, want e=1 others 0",
                     empty_o, full_o, almost_full_o, rd_valid_o, overflow_o, underflow_o);
        end
        checks++;
        if (count_o !== 5'd0 || data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: got count=%0d data=%h, want 0 and 0", count_o, data_o);
        end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 3; i++) begin
            wr_en_i = 1'b1;
            data_i = DW'(i);
            step();
        end
        wr_en_i = 1'b0;
        checks++;
        if (count_o !== 5'd3 || empty_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: got count=%0d empty=%b, want 3 and 0", count_o, empty_o);
        end
        rd_en_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (rd_valid_o !== 1'b1 || data_o !== DW'(i)) begin
                errors++;
                $display("FAIL basic_read%0d: got v=%b data=%h, want v=1 data=%h", i, rd_valid_o, data_o, DW'(i));
            end
        end
        rd_en_i = 1'b0;
        checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_drain: got count=%0d empty=%b, want 0 and 1", count_o, empty_o);
        end
        step();
        checks++;
        if (rd_valid_o !== 1'b0 || data_o !== 32'd3) begin
            errors++;
            $display("FAIL basic_idle: got v=%b data=%h, want v=0 data held at 3", rd_valid_o, data_o);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en_i = 1'b1;
            data_i = 32'h100 + DW'(i);
            step();
            checks++;
            if (count_o !== 5'(i + 1) || almost_full_o !== ((i + 1) >= 12) || full_o !== ((i + 1) == DEPTH)) begin
                errors++;
                $display("FAIL fill%0d: got count=%0d af=%b f=%b, want count=%0d af=%b f=%b", i, count_o,
                         almost_full_o, full_o, i + 1, ((i + 1) >= 12), ((i + 1) == DEPTH));
            end
        end
        data_i = 32'hDEADBEEF;
        step();
        wr_en_i = 1'b0;
        checks++;
        if (count_o !== 5'd16 || full_o !== 1'b1 || overflow_o !== FLAGS) begin
            errors++;
            $display("FAIL overflow: got count=%0d f=%b of=%b, want 16 1 %b", count_o, full_o, overflow_o, FLAGS);
        end
    endtask

    task automatic test_full_simul();
        wr_en_i = 1'b1;
        rd_en_i = 1'b1;
        data_i = 32'hCAFE0000;
        step();
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        checks++;
        if (rd_valid_o !== 1'b1 || data_o !== 32'h100 || count_o !== 5'd15) begin
            errors++;
            $display("FAIL full_simul: got v=%b data=%h count=%0d, want 1 00000100 15", rd_valid_o, data_o, count_o);
        end
        rd_en_i = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            step();
            checks++;
            if (rd_valid_o !== 1'b1 || data_o !== 32'h100 + DW'(i)) begin
                errors++;
                $display("FAIL drain%0d: got v=%b data=%h, want v=1 data=%h", i, rd_valid_o, data_o, 32'h100 + DW'(i));
            end
        end
        rd_en_i = 1'b0;
        checks++;
        if (empty_o !== 1'b1 || underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: got empty=%b uf=%b, want 1 0", empty_o, underflow_o);
        end
    endtask

    task automatic test_empty_simul();
        wr_en_i = 1'b1;
        rd_en_i = 1'b1;
        data_i = 32'h7;
        step();
        wr_en_i = 1'b0;
        checks++;
        if (rd_valid_o !== 1'b0 || count_o !== 5'd1 || underflow_o !== FLAGS) begin
            errors++;
            $display("FAIL empty_simul: got v=%b count=%0d uf=%b, want 0 1 %b", rd_valid_o, count_o, underflow_o, FLAGS);
        end
        step();
        rd_en_i = 1'b0;
        checks++;
        if (rd_valid_o !== 1'b1 || data_o !== 32'h7 || count_o !== 5'd0) begin
            errors++;
            $display("FAIL empty_next: got v=%b data=%h count=%0d, want 1 00000007 0", rd_valid_o, data_o, count_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_data;
        logic          exp_valid;
        int written = 0;
        int popped = 0;
        int cyc = 0;
        while ((written < 20 || popped < 20) && cyc < 200) begin
            wr_en_i = (written < 20) && (cyc % 4 != 3);
            rd_en_i = (cyc % 3 != 0) || (written >= 20);
            data_i = 32'h1000 + DW'(written);
            exp_valid = rd_en_i && (q.size() != 0);
            exp_data = exp_valid ? q.pop_front() : last_pop;
            if (wr_en_i && (q.size() + (exp_valid ? 1 : 0)) < DEPTH) begin
                q.push_back(data_i);
                written++;
            end
            step();
            if (exp_valid) begin
                popped++;
                last_pop = exp_data;
            end
            checks++;
            if (rd_valid_o !== exp_valid || (exp_valid && data_o !== exp_data) || count_o !== 5'(q.size())) begin
                errors++;
                $display("FAIL b2b_cyc%0d: got v=%b data=%h count=%0d, want v=%b data=%h count=%0d", cyc,
                         rd_valid_o, data_o, count_o, exp_valid, exp_data, q.size());
            end
            cyc++;
        end
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        checks++;
        if (popped != 20) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d pops, want 20", popped);
        end
    endtask

    task automatic test_clear_and_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en_i = 1'b1;
            data_i = 32'h50 + DW'(i);
            step();
        end
        rd_en_i = 1'b1;
        clrh_i = 1'b1;
        data_i = 32'h99;
        step();
        clrh_i = 1'b0;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1 || rd_valid_o !== 1'b0 || overflow_o !== 1'b0 ||
            underflow_o !== 1'b0 || data_o !== last_pop) begin
            errors++;
            $display("FAIL clear: got count=%0d e=%b v=%b of=%b uf=%b data=%h, want 0 1 0 0 0 data=%h",
                     count_o, empty_o, rd_valid_o, overflow_o, underflow_o, data_o, last_pop);
        end
        for (int i = 0; i < 4; i++) begin
            wr_en_i = 1'b1;
            data_i = 32'hA0 + DW'(i);
            step();
        end
        rd_en_i = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || almost_full_o !== 1'b0 ||
            rd_valid_o !== 1'b0 || data_o !== 32'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: got count=%0d e=%b f=%b af=%b v=%b data=%h of=%b uf=%b, want reset values",
                     count_o, empty_o, full_o, almost_full_o, rd_valid_o, data_o, overflow_o, underflow_o);
        end
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1) begin
            errors++;
            $display("FAIL post_rst: got count=%0d e=%b, want 0 1", count_o, empty_o);
        end
    endtask

    initial begin
        last_pop = '0;
        test_reset();
        test_basic();
        test_fill();
        test_full_simul();
        test_empty_simul();
        last_pop = 32'h7;
        test_back_to_back();
        test_clear_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
